// File: rtl/sp_ram_resp.sv
// Behavioural single-port RAM responder: self-clearing init sweep, 1- or 2-cycle read latency,
// write-first/read-first modes and saturating access counters. Parity storage under `SP_RAM_PARITY_EN.
module sp_ram_resp #(
  parameter int                ADDR_W   = 5,
  parameter int                DATA_W   = 8,
  parameter int                RD_LAT   = 1,
  parameter int                WR_MODE  = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_en,
  input  logic              ram_we,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_wr_data,
`ifdef SP_RAM_PARITY_EN
  input  logic              par_inj,
  output logic              par_err,
`endif
  output logic [DATA_W-1:0] ram_rd_data,
  output logic              rd_valid,
  output logic              init_done,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef SP_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  generate
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $error("sp_ram_resp: RD_LAT must be 1 or 2");
    end
    if (WR_MODE != 0 && WR_MODE != 1) begin : g_bad_wr_mode
      $error("sp_ram_resp: WR_MODE must be 0 or 1");
    end
  endgenerate

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_addr;
  logic [MEM_W-1:0]  mem [DEPTH];

  logic              acc;
  logic              acc_wr;
  logic              acc_rd;
  logic [MEM_W-1:0]  init_word;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  old_word;
  logic [MEM_W-1:0]  acc_word;
  logic [MEM_W-1:0]  out_word;
  logic              out_valid;

  // Bus accesses only count once the sweep has finished.
  assign acc    = (state == ST_RUN) && ram_en;
  assign acc_wr = acc && ram_we;
  assign acc_rd = acc && !ram_we;

`ifdef SP_RAM_PARITY_EN
  assign init_word = {^INIT_VAL, INIT_VAL};
  assign wr_word   = {(^ram_wr_data) ^ par_inj, ram_wr_data};
`else
  assign init_word = INIT_VAL;
  assign wr_word   = ram_wr_data;
`endif

  assign old_word = mem[ram_addr];
  assign acc_word = (acc_wr && (WR_MODE == 0)) ? wr_word : old_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_addr <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_addr <= init_addr + 1'b1;
          if (init_addr == {ADDR_W{1'b1}}) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  // The array is deliberately not reset; the sweep overwrites every word after each reset.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[init_addr] <= init_word;
    end else if (acc_wr) begin
      mem[ram_addr] <= wr_word;
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_word  <= '0;
          out_valid <= 1'b0;
        end else begin
          out_valid <= acc_rd;
          if (acc) begin
            out_word <= acc_word;
          end
        end
      end
    end else begin : g_lat2
      logic [MEM_W-1:0] s1_word;
      logic             s1_upd;
      logic             s1_rd;

      // Stage 1 remembers whether it holds an access so idle cycles leave the output untouched.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_word   <= '0;
          s1_upd    <= 1'b0;
          s1_rd     <= 1'b0;
          out_word  <= '0;
          out_valid <= 1'b0;
        end else begin
          s1_upd    <= acc;
          s1_rd     <= acc_rd;
          out_valid <= s1_rd;
          if (acc) begin
            s1_word <= acc_word;
          end
          if (s1_upd) begin
            out_word <= s1_word;
          end
        end
      end
    end
  endgenerate

  assign ram_rd_data = out_word[DATA_W-1:0];
  assign rd_valid    = out_valid;

`ifdef SP_RAM_PARITY_EN
  assign par_err = out_valid & (out_word[DATA_W] ^ (^out_word[DATA_W-1:0]));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (acc_wr && (wr_cnt != 16'hFFFF)) begin
        wr_cnt <= wr_cnt + 16'd1;
      end
      if (acc_rd && (rd_cnt != 16'hFFFF)) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sp_ram_resp.sv
// Self-checking bench for sp_ram_resp: two instances (RD_LAT=1/write-first and RD_LAT=2/read-first)
// driven by one bus and compared every cycle against an array-based reference model.
module tb_sp_ram_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_en;
  logic        ram_we;
  logic [4:0]  ram_addr;
  logic [7:0]  ram_wr_data;

  logic [7:0]  rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1;
  logic        init_done0, init_done1;
  logic [15:0] wr_cnt0, wr_cnt1;
  logic [15:0] rd_cnt0, rd_cnt1;
`ifdef SP_RAM_PARITY_EN
  logic        par_inj;
  logic        par_err0, par_err1;
  logic        mp [2][32];
  logic        p_bad [2];
  logic        exp_perr [2];
`endif

  int checks   = 0;
  int failures = 0;

  int         lat  [2] = '{1, 2};
  int         mode [2] = '{0, 1};
  logic [7:0] ival [2] = '{8'h00, 8'h5A};

  logic [7:0] mm [2][32];
  int         edges;
  logic       p_upd [2];
  logic       p_rd [2];
  logic [7:0] p_data [2];
  logic [7:0] exp_data [2];
  logic       exp_valid [2];
  int         exp_wr [2];
  int         exp_rd [2];
  logic       exp_done;

  always #5 clk = ~clk;

  sp_ram_resp #(
    .ADDR_W(5), .DATA_W(8), .RD_LAT(1), .WR_MODE(0), .INIT_VAL(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
`ifdef SP_RAM_PARITY_EN
    .par_inj(par_inj), .par_err(par_err0),
`endif
    .ram_rd_data(rd_data0), .rd_valid(rd_valid0), .init_done(init_done0),
    .wr_cnt(wr_cnt0), .rd_cnt(rd_cnt0)
  );

  sp_ram_resp #(
    .ADDR_W(5), .DATA_W(8), .RD_LAT(2), .WR_MODE(1), .INIT_VAL(8'h5A)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
`ifdef SP_RAM_PARITY_EN
    .par_inj(par_inj), .par_err(par_err1),
`endif
    .ram_rd_data(rd_data1), .rd_valid(rd_valid1), .init_done(init_done1),
    .wr_cnt(wr_cnt1), .rd_cnt(rd_cnt1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    edges    = 0;
    exp_done = 1'b0;
    for (int d = 0; d < 2; d++) begin
      p_upd[d]     = 1'b0;
      p_rd[d]      = 1'b0;
      p_data[d]    = '0;
      exp_data[d]  = '0;
      exp_valid[d] = 1'b0;
      exp_wr[d]    = 0;
      exp_rd[d]    = 0;
`ifdef SP_RAM_PARITY_EN
      p_bad[d]    = 1'b0;
      exp_perr[d] = 1'b0;
`endif
    end
  endtask

  // One rising edge of the reference model, using the bus values the DUTs just sampled.
  task automatic model_edge();
    logic       upd, rd, tu, tr;
    logic [7:0] data, td;
    logic [4:0] a;
`ifdef SP_RAM_PARITY_EN
    logic       bad, tb;
`endif
    if (!rst_n) begin
      model_reset();
      return;
    end
    a = ram_addr;
    for (int d = 0; d < 2; d++) begin
      upd  = 1'b0;
      rd   = 1'b0;
      data = '0;
`ifdef SP_RAM_PARITY_EN
      bad = 1'b0;
`endif
      if (edges < 32) begin
        mm[d][edges[4:0]] = ival[d];
`ifdef SP_RAM_PARITY_EN
        mp[d][edges[4:0]] = ^ival[d];
`endif
      end else if (ram_en) begin
        upd = 1'b1;
        rd  = !ram_we;
        if (ram_we) begin
          data     = (mode[d] != 0) ? mm[d][a] : ram_wr_data;
          mm[d][a] = ram_wr_data;
`ifdef SP_RAM_PARITY_EN
          mp[d][a] = (^ram_wr_data) ^ par_inj;
`endif
          if (exp_wr[d] < 65535) exp_wr[d]++;
        end else begin
          data = mm[d][a];
`ifdef SP_RAM_PARITY_EN
          bad = (mp[d][a] != ^mm[d][a]);
`endif
          if (exp_rd[d] < 65535) exp_rd[d]++;
        end
      end
      if (lat[d] == 2) begin
        tu = p_upd[d];  p_upd[d]  = upd;  upd  = tu;
        tr = p_rd[d];   p_rd[d]   = rd;   rd   = tr;
        td = p_data[d]; p_data[d] = data; data = td;
`ifdef SP_RAM_PARITY_EN
        tb = p_bad[d];  p_bad[d]  = bad;  bad  = tb;
`endif
      end
      exp_valid[d] = rd;
      if (upd) exp_data[d] = data;
`ifdef SP_RAM_PARITY_EN
      exp_perr[d] = rd & bad;
`endif
    end
    exp_done = (edges >= 31);
    edges++;
  endtask

  task automatic checkAll();
    checkOutput("d0.rd_data",   rd_data0,   exp_data[0]);
    checkOutput("d0.rd_valid",  rd_valid0,  exp_valid[0]);
    checkOutput("d0.init_done", init_done0, exp_done);
    checkOutput("d0.wr_cnt",    wr_cnt0,    exp_wr[0]);
    checkOutput("d0.rd_cnt",    rd_cnt0,    exp_rd[0]);
    checkOutput("d1.rd_data",   rd_data1,   exp_data[1]);
    checkOutput("d1.rd_valid",  rd_valid1,  exp_valid[1]);
    checkOutput("d1.init_done", init_done1, exp_done);
    checkOutput("d1.wr_cnt",    wr_cnt1,    exp_wr[1]);
    checkOutput("d1.rd_cnt",    rd_cnt1,    exp_rd[1]);
`ifdef SP_RAM_PARITY_EN
    checkOutput("d0.par_err",   par_err0,   exp_perr[0]);
    checkOutput("d1.par_err",   par_err1,   exp_perr[1]);
`endif
  endtask

  // Called between edges; drives the bus, lets one edge pass, then checks 1 ns later.
  task automatic applyStimulus(input logic en, input logic we, input logic [4:0] a, input logic [7:0] wd);
    ram_en      = en;
    ram_we      = we;
    ram_addr    = a;
    ram_wr_data = wd;
    @(posedge clk);
    model_edge();
    #1;
    checkAll();
  endtask

  task automatic midReset();
    #4;
    rst_n = 1'b0;
    #1;
    model_reset();
    checkAll();
    @(posedge clk);
    model_edge();
    #1;
    checkAll();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wr_data = '0;
`ifdef SP_RAM_PARITY_EN
    par_inj = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;

    // Bus active throughout the sweep: everything must be dropped.
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, i[0], 5'(i), 8'($urandom));

    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b1, 5'(i), 8'(i));
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b0, 5'(i), 8'h00);
    repeat (2) applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);

    applyStimulus(1'b1, 1'b1, 5'd7, 8'hA5);
    applyStimulus(1'b1, 1'b0, 5'd7, 8'h00);
    repeat (3) applyStimulus(1'b0, 1'b0, 5'd7, 8'h00);

    // Back-to-back write then read of the same address across the 31->0 wrap.
    applyStimulus(1'b1, 1'b1, 5'd31, 8'hC3);
    applyStimulus(1'b1, 1'b0, 5'd31, 8'h00);
    applyStimulus(1'b1, 1'b1, 5'd0, 8'h3C);
    applyStimulus(1'b1, 1'b0, 5'd0, 8'h00);

    for (int i = 0; i < 300; i++) begin
`ifdef SP_RAM_PARITY_EN
      par_inj = ($urandom_range(0, 7) == 0);
`endif
      applyStimulus(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                    5'($urandom), 8'($urandom));
    end
`ifdef SP_RAM_PARITY_EN
    par_inj = 1'b0;
`endif
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);

    // Counter saturation: preload near the top, then read past it.
    force dut.rd_cnt  = 16'hFFFE;
    force dut2.rd_cnt = 16'hFFFE;
    #1;
    release dut.rd_cnt;
    release dut2.rd_cnt;
    exp_rd[0] = 65534;
    exp_rd[1] = 65534;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 5'(i), 8'h00);
    repeat (2) applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);

    // Reset in the middle of a read burst, then re-sweep with the bus busy.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 5'(i + 8), 8'h00);
    midReset();
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, $urandom_range(0, 1) == 1, 5'($urandom), 8'($urandom));
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b0, 5'(i), 8'h00);
    repeat (2) applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);

`ifdef SP_RAM_PARITY_EN
    par_inj = 1'b1;
    applyStimulus(1'b1, 1'b1, 5'd4, 8'h3C);
    par_inj = 1'b0;
    applyStimulus(1'b1, 1'b0, 5'd4, 8'h00);
    repeat (2) applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
    applyStimulus(1'b1, 1'b1, 5'd4, 8'h3C);
    applyStimulus(1'b1, 1'b0, 5'd4, 8'h00);
    repeat (2) applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
